// File: rtl/mau_pkg.sv
// ============================================================================
// Module : mau_pkg
// Brief  : Shared types and constants for the memory access unit and data RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mau_pkg;

    localparam logic [15:0] RAM_BOUND_L  = 16'h0200;
    localparam logic [15:0] RAM_BOUND_U  = 16'h0400;
    localparam int          RAM_WAIT_MAX = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_WR      = 3'd2,
        S_WR_WAIT = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic [15:0] byte_lane(input logic [15:0] i_d);
        return {8'h00, i_d[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mau_decode.sv
// ============================================================================
// Module : mau_decode
// Brief  : Address range check, word alignment and RAM offset calculation.
//          MAU_ALIGN_TRAP_EN: odd word addresses are flagged instead of cleared.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mau_decode
    import mau_pkg::*;
#(
    parameter logic [15:0] BOUND_L = RAM_BOUND_L,
    parameter logic [15:0] BOUND_U = RAM_BOUND_U
) (
    input  logic [15:0] i_addr,
    input  logic        i_bw,
    output logic [15:0] o_offset,
    output logic [1:0]  o_cause
);

    logic [15:0] w_addr_al;
    logic        w_in_range;
    logic        w_misaligned;

    assign w_addr_al  = i_bw ? i_addr : {i_addr[15:1], 1'b0};
    assign w_in_range = (w_addr_al >= BOUND_L) && (w_addr_al < BOUND_U);

`ifdef MAU_ALIGN_TRAP_EN
    assign w_misaligned = ~i_bw & i_addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        o_cause = ERR_NONE;
        if (!w_in_range) begin
            o_cause = ERR_RANGE;
        end else if (w_misaligned) begin
            o_cause = ERR_ALIGN;
        end
    end

    // Only meaningful when in range; the top ignores it otherwise.
    assign o_offset = w_addr_al - BOUND_L;

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Single-outstanding load/store sequencer in front of the data RAM.
//          Optional macro MAU_ALIGN_TRAP_EN (handled in mau_decode).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter logic [15:0] BOUND_L  = RAM_BOUND_L,
    parameter logic [15:0] BOUND_U  = RAM_BOUND_U,
    parameter int          WAIT_MAX = RAM_WAIT_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_we,
    input  logic        req_bw,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_Din,
    output logic        ram_RW,
    output logic        ram_BW,
    input  logic        ram_write_done,
    input  logic [15:0] ram_out
);

    localparam int               CNT_W       = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [15:0]       r_ram_addr;
    logic [15:0]       r_ram_din;
    logic              r_ram_bw;
    logic [15:0]       r_resp_rdata;
    logic              r_resp_err;

    logic [15:0]       w_offset;
    logic [1:0]        w_cause;
    logic              w_dec_err;
    logic              w_wait_expired;

    mau_decode #(
        .BOUND_L (BOUND_L),
        .BOUND_U (BOUND_U)
    ) u_decode (
        .i_addr   (req_addr),
        .i_bw     (req_bw),
        .o_offset (w_offset),
        .o_cause  (w_cause)
    );

    assign w_dec_err      = (w_cause != ERR_NONE);
    assign w_wait_expired = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_RW      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_dec_err) begin
                        w_state_nxt = S_RESP;
                    end else if (req_we) begin
                        w_state_nxt = S_WR;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD:      w_state_nxt = S_RESP;
            S_WR: begin
                ram_RW      = 1'b1;
                w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (ram_write_done || w_wait_expired) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Response fields are written on entry to RESP and then hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_bw     <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_dec_err) begin
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_ram_addr <= w_offset;
                            r_ram_bw   <= req_bw;
                            r_ram_din  <= req_bw ? byte_lane(req_wdata) : req_wdata;
                        end
                    end
                end
                S_RD: begin
                    r_resp_rdata <= r_ram_bw ? byte_lane(ram_out) : ram_out;
                    r_resp_err   <= 1'b0;
                end
                S_WR: begin
                    r_wait_cnt <= '0;
                end
                S_WR_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (ram_write_done) begin
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b0;
                    end else if (w_wait_expired) begin
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign ram_addr   = r_ram_addr;
    assign ram_Din    = r_ram_din;
    assign ram_BW     = r_ram_bw;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench for mem_access_unit with a byte RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_we;
    logic        req_bw;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] ram_addr;
    logic [15:0] ram_Din;
    logic        ram_RW;
    logic        ram_BW;
    logic        ram_write_done;
    logic [15:0] ram_out;

    logic [7:0]  mem [0:511];
    logic        tb_init;
    logic        ack_en;
    logic        r_done;
    int          strobe_cnt;
    logic [15:0] strb_addr;
    logic [15:0] strb_din;
    logic        strb_bw;

    int          n_checks;
    int          n_fail;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_we         (req_we),
        .req_bw         (req_bw),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_addr       (ram_addr),
        .ram_Din        (ram_Din),
        .ram_RW         (ram_RW),
        .ram_BW         (ram_BW),
        .ram_write_done (ram_write_done),
        .ram_out        (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte RAM; initial content is byte i = i[7:0] ^ 8'hA5.
    assign ram_out        = {mem[ram_addr[8:0] + 9'd1], mem[ram_addr[8:0]]};
    assign ram_write_done = r_done;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
            strobe_cnt <= 0;
            r_done     <= 1'b0;
            strb_addr  <= '0;
            strb_din   <= '0;
            strb_bw    <= 1'b0;
        end else begin
            if (ram_RW) begin
                mem[ram_addr[8:0]] <= ram_Din[7:0];
                if (!ram_BW) mem[ram_addr[8:0] + 9'd1] <= ram_Din[15:8];
                strobe_cnt <= strobe_cnt + 1;
                strb_addr  <= ram_addr;
                strb_din   <= ram_Din;
                strb_bw    <= ram_BW;
            end
            r_done <= ram_RW & ack_en;
        end
    end

    // Issues one request from IDLE; lat counts negedges after the accepting edge (-1 = none).
    task automatic do_req(input logic we, input logic bw, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat,
                          output logic [15:0] rdata, output logic err, output int strobes);
        int s0;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        s0 = strobe_cnt;
        req_valid = 1'b1; req_we = we; req_bw = bw; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(negedge clk);
        end
        strobes = strobe_cnt - s0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tb_init = 1'b1;
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        n_checks++; if ({resp_valid, ram_RW, ram_BW, resp_err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b exp 0000", {resp_valid, ram_RW, ram_BW, resp_err}); end
        n_checks++; if ({ram_addr, ram_Din, resp_rdata} !== 48'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", {ram_addr, ram_Din, resp_rdata}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        int lat, st; logic [15:0] rd; logic er;
        do_req(1'b1, 1'b0, 16'h0210, 16'hBEEF, lat, rd, er, st);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wst_lat: got %0d exp 3", lat); end
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL wst_strobes: got %0d exp 1", st); end
        n_checks++; if (strb_addr !== 16'h0010) begin n_fail++; $display("FAIL wst_addr: got %h exp 0010", strb_addr); end
        n_checks++; if ({strb_din, strb_bw} !== {16'hBEEF, 1'b0}) begin n_fail++; $display("FAIL wst_din: got %h/%b exp beef/0", strb_din, strb_bw); end
        n_checks++; if ({er, rd} !== 17'h0) begin n_fail++; $display("FAIL wst_resp: got err %b data %h exp 0/0000", er, rd); end
        do_req(1'b0, 1'b0, 16'h0210, 16'h0000, lat, rd, er, st);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wld_lat: got %0d exp 2", lat); end
        n_checks++; if ({er, rd} !== {1'b0, 16'hBEEF}) begin n_fail++; $display("FAIL wld_data: got err %b data %h exp 0/beef", er, rd); end
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL wld_strobes: got %0d exp 0", st); end
    endtask

    task automatic test_byte_access();
        int lat, st; logic [15:0] rd; logic er;
        do_req(1'b1, 1'b1, 16'h0211, 16'h125A, lat, rd, er, st);
        n_checks++; if (lat !== 3 || st !== 1) begin n_fail++; $display("FAIL bst_lat: got lat %0d strobes %0d exp 3/1", lat, st); end
        n_checks++; if ({strb_addr, strb_din, strb_bw} !== {16'h0011, 16'h005A, 1'b1}) begin n_fail++; $display("FAIL bst_ram: got %h %h %b exp 0011 005a 1", strb_addr, strb_din, strb_bw); end
        do_req(1'b0, 1'b0, 16'h0210, 16'h0000, lat, rd, er, st);
        n_checks++; if ({er, rd} !== {1'b0, 16'h5AEF}) begin n_fail++; $display("FAIL bst_word_rd: got err %b data %h exp 0/5aef", er, rd); end
        do_req(1'b0, 1'b1, 16'h0211, 16'h0000, lat, rd, er, st);
        n_checks++; if (lat !== 2 || {er, rd} !== {1'b0, 16'h005A}) begin n_fail++; $display("FAIL bld_data: got lat %0d err %b data %h exp 2/0/005a", lat, er, rd); end
    endtask

    task automatic test_range();
        int lat, st; logic [15:0] rd; logic er;
        do_req(1'b0, 1'b0, 16'h0400, 16'h0000, lat, rd, er, st);
        n_checks++; if (lat !== 1 || st !== 0) begin n_fail++; $display("FAIL oor_ld_lat: got lat %0d strobes %0d exp 1/0", lat, st); end
        n_checks++; if ({er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL oor_ld_resp: got err %b data %h exp 1/0000", er, rd); end
        do_req(1'b1, 1'b1, 16'h01FF, 16'hFFFF, lat, rd, er, st);
        n_checks++; if (lat !== 1 || st !== 0 || {er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL oor_st: got lat %0d strobes %0d err %b data %h exp 1/0/1/0000", lat, st, er, rd); end
        do_req(1'b0, 1'b1, 16'h03FF, 16'h0000, lat, rd, er, st);
        n_checks++; if (lat !== 2 || {er, rd} !== {1'b0, 16'h005A}) begin n_fail++; $display("FAIL top_byte: got lat %0d err %b data %h exp 2/0/005a", lat, er, rd); end
        do_req(1'b0, 1'b0, 16'h03FF, 16'h0000, lat, rd, er, st);
`ifdef MAU_ALIGN_TRAP_EN
        n_checks++; if (lat !== 1 || {er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL top_word: got lat %0d err %b data %h exp 1/1/0000", lat, er, rd); end
`else
        n_checks++; if (lat !== 2 || {er, rd} !== {1'b0, 16'h5A5B}) begin n_fail++; $display("FAIL top_word: got lat %0d err %b data %h exp 2/0/5a5b", lat, er, rd); end
        n_checks++; if (ram_addr !== 16'h01FE) begin n_fail++; $display("FAIL top_word_addr: got %h exp 01fe", ram_addr); end
`endif
    endtask

    task automatic test_unaligned();
        int lat, st; logic [15:0] rd; logic er;
        do_req(1'b0, 1'b0, 16'h0213, 16'h0000, lat, rd, er, st);
`ifdef MAU_ALIGN_TRAP_EN
        n_checks++; if (lat !== 1 || st !== 0 || {er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL unal: got lat %0d strobes %0d err %b data %h exp 1/0/1/0000", lat, st, er, rd); end
`else
        n_checks++; if (lat !== 2 || {er, rd} !== {1'b0, 16'hB6B7}) begin n_fail++; $display("FAIL unal: got lat %0d err %b data %h exp 2/0/b6b7", lat, er, rd); end
        n_checks++; if (ram_addr !== 16'h0012) begin n_fail++; $display("FAIL unal_addr: got %h exp 0012", ram_addr); end
`endif
    endtask

    task automatic test_timeout();
        int lat, st; logic [15:0] rd; logic er;
        ack_en = 1'b0;
        do_req(1'b1, 1'b0, 16'h0220, 16'h1234, lat, rd, er, st);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL tmo_lat: got %0d exp 6", lat); end
        n_checks++; if (st !== 1 || {er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL tmo_resp: got strobes %0d err %b data %h exp 1/1/0000", st, er, rd); end
        ack_en = 1'b1;
        do_req(1'b0, 1'b0, 16'h0220, 16'h0000, lat, rd, er, st);
        n_checks++; if (lat !== 2 || {er, rd} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL tmo_next: got lat %0d err %b data %h exp 2/0/1234", lat, er, rd); end
    endtask

    task automatic test_reset_busy();
        int lat, st, s0; logic [15:0] rd; logic er;
        do_req(1'b0, 1'b0, 16'h0212, 16'h0000, lat, rd, er, st);
        n_checks++; if (rd !== 16'hB6B7) begin n_fail++; $display("FAIL busy_pre: got %h exp b6b7", rd); end
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        ack_en = 1'b0;
        s0 = strobe_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_bw = 1'b0; req_addr = 16'h0230; req_wdata = 16'h7777;
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0210; req_wdata = 16'h0000;
        @(negedge clk);
        n_checks++; if ({req_ready, resp_valid, ram_RW} !== 3'b000) begin n_fail++; $display("FAIL busy_wait: got rdy/vld/rw %b exp 000", {req_ready, resp_valid, ram_RW}); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({req_ready, resp_valid, ram_RW, ram_BW, resp_err} !== 5'b10000) begin n_fail++; $display("FAIL busy_rst_flags: got %b exp 10000", {req_ready, resp_valid, ram_RW, ram_BW, resp_err}); end
        n_checks++; if ({ram_addr, ram_Din, resp_rdata} !== 48'h0) begin n_fail++; $display("FAIL busy_rst_data: got %h exp 0", {ram_addr, ram_Din, resp_rdata}); end
        rst = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_accept: got ready %b exp 0", req_ready); end
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 16'h5AEF}) begin n_fail++; $display("FAIL busy_resp: got vld %b err %b data %h exp 1/0/5aef", resp_valid, resp_err, resp_rdata); end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL busy_strobes: got %0d exp 1", strobe_cnt - s0); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_bw = 1'b0;
        ack_en = 1'b1; tb_init = 1'b1; rst = 1'b1;
        test_reset();
        test_word_store_load();
        test_byte_access();
        test_range();
        test_unaligned();
        test_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
